// File: rtl/sha1_msg_sched_if.sv
// Block-in / word-out bus of the SHA-1 message schedule.
// The slave modport is the schedule itself; the master modport is the
// side that supplies blocks and consumes schedule words.
interface sha1_msg_sched_if;
  logic         abort;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w;
  logic [7:0]   round;
  logic         done;

  modport slave (
    input  abort, blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w, round, done
  );

  modport master (
    output abort, blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w, round, done
  );
endinterface

// File: rtl/sha1_msg_sched.sv
// SHA-1 message schedule.
// Accepts one padded 512-bit block and streams W_0..W_79 tagged with
// rounds 1..80. A 16-word sliding window replaces the 80-word array:
// win[0] is always the word on offer, and each accepted word shifts the
// window and appends the next expanded word at win[15].
module sha1_msg_sched #(
  parameter int N      = 32,  // word width, SHA-1 fixes this at 32
  parameter int ROUNDS = 80   // rounds per block, SHA-1 fixes this at 80
) (
  input logic            clk,
  input logic            rst_n,
  sha1_msg_sched_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state;
  logic [N-1:0] win [16];
  logic [N-1:0] mix;
  logic [N-1:0] w_next;

  // Next schedule word: W_t = ROTL1(W_{t-3} ^ W_{t-8} ^ W_{t-14} ^ W_{t-16}).
  // With win[0] = W_{t-16}, those taps sit at win[13], win[8], win[2], win[0].
  always_comb begin
    mix    = win[13] ^ win[8] ^ win[2] ^ win[0];
    w_next = {mix[N-2:0], mix[N-1]};
  end

  // The word on offer is the head of the window, already a register.
  assign bus.w = win[0];

  // Control FSM, round counter and window shift register.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; the window shift depends on that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.blk_ready <= 1'b1;
      bus.w_valid   <= 1'b0;
      bus.round     <= '0;
      bus.done      <= 1'b0;
      // NOTE: the window is cleared on reset so w reads 0 out of reset;
      // it is small enough to be flops, not a RAM, so this costs nothing odd.
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      bus.done <= 1'b0;
      if (bus.abort) begin
        // Abort wins over any handshake in the same cycle; win is kept.
        state         <= IDLE;
        bus.blk_ready <= 1'b1;
        bus.w_valid   <= 1'b0;
        bus.round     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.blk_valid && bus.blk_ready) begin
              // M0 is the most significant word of the block.
              for (int i = 0; i < 16; i++)
                win[i] <= bus.blk_data[16*N-1-N*i -: N];
              state         <= RUN;
              bus.blk_ready <= 1'b0;
              bus.w_valid   <= 1'b1;
              bus.round     <= 8'd1;
            end
          end
          RUN: begin
            if (bus.w_ready) begin
              if (bus.round == 8'(ROUNDS)) begin
                state         <= IDLE;
                bus.blk_ready <= 1'b1;
                bus.w_valid   <= 1'b0;
                bus.round     <= '0;
                bus.done      <= 1'b1;
              end else begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15]   <= w_next;
                bus.round <= bus.round + 8'd1;
              end
            end
          end
          default: begin
            state         <= IDLE;
            bus.blk_ready <= 1'b1;
            bus.w_valid   <= 1'b0;
            bus.round     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha1_msg_sched.sv
// Self-checking bench for sha1_msg_sched.
// A reference model expands the whole block into an 80-word array and
// tracks which round should be on offer; a compare process checks the DUT
// against it every cycle, and directed tests pin literal values.
module tb_sha1_msg_sched;

  typedef logic [31:0] warr_t [80];

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK2    = {32'hDEADBEEF, {15{32'h5A5AA5A5}}};
  localparam logic [159:0] ABC_DIGEST =
    160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha1_msg_sched_if bus ();

  sha1_msg_sched dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] cap [$];

  // Model state
  logic       m_busy;
  logic [7:0] m_round;
  logic       m_done;
  warr_t      m_w;

  task automatic check(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic warr_t expand(input logic [511:0] blk);
    warr_t w;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++)
      w[t] = rotl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    return w;
  endfunction

  function automatic logic [159:0] sha1_digest(input warr_t w);
    logic [31:0] a, b, c, d, e, f, k, tmp;
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE;
    d = 32'h10325476; e = 32'hC3D2E1F0;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = rotl(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rotl(b, 30); b = a; a = tmp;
    end
    return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE,
            d + 32'h10325476, e + 32'hC3D2E1F0};
  endfunction

  function automatic warr_t cap_to_arr();
    warr_t w;
    for (int t = 0; t < 80; t++) w[t] = (t < cap.size()) ? cap[t] : 32'h0;
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: which word/round must be on offer next cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_round <= 8'd0;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (bus.abort) begin
        m_busy  <= 1'b0;
        m_round <= 8'd0;
      end else if (!m_busy) begin
        if (bus.blk_valid) begin
          m_busy  <= 1'b1;
          m_round <= 8'd1;
          m_w     <= expand(bus.blk_data);
        end
      end else if (bus.w_ready) begin
        if (m_round == 8'd80) begin
          m_busy  <= 1'b0;
          m_round <= 8'd0;
          m_done  <= 1'b1;
        end else begin
          m_round <= m_round + 8'd1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_blk_ready", 160'(bus.blk_ready), 160'(!m_busy));
      check("cyc_w_valid",   160'(bus.w_valid),   160'(m_busy));
      check("cyc_round",     160'(bus.round),     160'(m_round));
      check("cyc_done",      160'(bus.done),      160'(m_done));
      if (m_busy && m_round >= 8'd1 && m_round <= 8'd80)
        check("cyc_w", 160'(bus.w), 160'(m_w[int'(m_round) - 1]));
    end
  end

  // Record every accepted schedule word.
  always @(posedge clk) begin
    if (rst_n && bus.w_valid && bus.w_ready && !bus.abort)
      cap.push_back(bus.w);
  end

  task automatic send_block(input logic [511:0] data, input string name);
    bit ok = 1'b0;
    bus.blk_data  = data;
    bus.blk_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (bus.blk_ready) begin ok = 1'b1; break; end
    end
    #1;
    bus.blk_valid = 1'b0;
    bus.blk_data  = {16{32'hBAD0BAD0}};
    if (!ok) check({name, "_accept_timeout"}, 160'(0), 160'(1));
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1'b1; break; end
    end
    if (!ok) check({name, "_done_timeout"}, 160'(0), 160'(1));
  endtask

  task automatic wait_round(input logic [7:0] r, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.round == r) begin ok = 1'b1; break; end
    end
    if (!ok) check({name, "_round_timeout"}, 160'(0), 160'(1));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_w"},         160'(bus.w),         160'(0));
    check({name, "_round"},     160'(bus.round),     160'(0));
    check({name, "_blk_ready"}, 160'(bus.blk_ready), 160'(1));
    check({name, "_w_valid"},   160'(bus.w_valid),   160'(0));
    check({name, "_done"},      160'(bus.done),      160'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    warr_t ref_w;
    int    acc_cyc;
    int    stall;
    bit    ok;

    bus.abort     = 1'b0;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.w_ready   = 1'b0;

    // Model pin: hand-computed expansion of the "abc" block.
    ref_w = expand(ABC_BLK);
    check("model_w16", 160'(ref_w[16]), 160'(32'hC2C4C700));
    check("model_w19", 160'(ref_w[19]), 160'(32'h85898E01));
    check("model_digest", sha1_digest(ref_w), ABC_DIGEST);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // T1/T2: "abc" block with w_ready held high
    bus.w_ready = 1'b1;
    cap.delete();
    send_block(ABC_BLK, "t1");
    acc_cyc = cyc;
    @(negedge clk);
    check("t1_first_w",     160'(bus.w),     160'(32'h61626380));
    check("t1_first_round", 160'(bus.round), 160'(1));
    wait_done("t1");
    check("t1_done_latency", 160'(cyc - acc_cyc), 160'(80));
    check("t1_count", 160'(cap.size()), 160'(80));
    check("t1_w0",  160'(cap_to_arr()[0]),  160'(32'h61626380));
    check("t1_w15", 160'(cap_to_arr()[15]), 160'(32'h00000018));
    check("t1_w16", 160'(cap_to_arr()[16]), 160'(32'hC2C4C700));
    check("t1_w17", 160'(cap_to_arr()[17]), 160'(32'h00000000));
    check("t1_w18", 160'(cap_to_arr()[18]), 160'(32'h00000030));
    check("t1_w19", 160'(cap_to_arr()[19]), 160'(32'h85898E01));
    check("t2_digest", sha1_digest(cap_to_arr()), ABC_DIGEST);

    // T3: forced 3-cycle stall at round 17 plus random w_ready toggling
    cap.delete();
    stall = 0;
    bus.w_ready = 1'b0;
    send_block(ABC_BLK, "t3");
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1'b1; break; end
      if (m_round == 8'd17 && stall < 3) begin
        bus.w_ready = 1'b0;
        stall++;
      end else begin
        bus.w_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!ok) check("t3_done_timeout", 160'(0), 160'(1));
    bus.w_ready = 1'b1;
    check("t3_count", 160'(cap.size()), 160'(80));
    for (int t = 0; t < 80; t++)
      check("t3_word", 160'(cap_to_arr()[t]), 160'(ref_w[t]));

    // T4: second block held valid during RUN
    cap.delete();
    send_block(ABC_BLK, "t4a");
    bus.blk_data  = BLK2;
    bus.blk_valid = 1'b1;
    wait_done("t4a");
    check("t4_ready_at_done", 160'(bus.blk_ready), 160'(1));
    @(posedge clk); #1;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    @(negedge clk);
    check("t4_second_w0",    160'(bus.w),     160'(32'hDEADBEEF));
    check("t4_second_round", 160'(bus.round), 160'(1));
    wait_done("t4b");
    check("t4_count", 160'(cap.size()), 160'(160));

    // T5: abort at round 40, then a fresh block
    send_block(ABC_BLK, "t5");
    wait_round(8'd40, "t5");
    bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    check("t5_round",     160'(bus.round),     160'(0));
    check("t5_w_valid",   160'(bus.w_valid),   160'(0));
    check("t5_blk_ready", 160'(bus.blk_ready), 160'(1));
    check("t5_done",      160'(bus.done),      160'(0));
    cap.delete();
    send_block(ABC_BLK, "t5b");
    @(negedge clk);
    check("t5_restart_round", 160'(bus.round), 160'(1));
    wait_done("t5b");
    check("t5_digest", sha1_digest(cap_to_arr()), ABC_DIGEST);

    // T6: asynchronous reset at round 55, then rerun
    send_block(ABC_BLK, "t6");
    wait_round(8'd55, "t6");
    #2 rst_n = 1'b0;
    #1 check_reset_values("t6_async");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cap.delete();
    send_block(ABC_BLK, "t6b");
    wait_done("t6b");
    check("t6_count", 160'(cap.size()), 160'(80));
    check("t6_digest", sha1_digest(cap_to_arr()), ABC_DIGEST);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
